ex_memlane_sched: RTL

- Schedules the single L1D response port between the lane-1 and lane-2 memory ops of one bundle in the EX3 stage.
- Lane 1 always runs first, then lane 2. The block latches lane-1 load data while lane 2 runs.
- Drives the EX3 pipeline hold, a saturating hold-cycle counter and a one-cycle memory-fault pulse.
- Sits between the EX3 lanes and the L1D data return.

---
 rtl/ex_memlane_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ex_memlane_sched.sv
// ---------------------------------------------------------------------------
// ex_memlane_sched
//
// EX3 memory-lane scheduler. The bundle's lane-1 and lane-2 memory ops share
// the single L1D response port. Lane 1 is serviced first. If lane 2 also has
// an op, the lane-1 writeback ID and data are latched and the FSM moves to
// RUN2 to service lane 2. Both writebacks are then presented together in the
// cycle the bundle completes. While the bundle is incomplete, exHold stalls
// the pipeline. holdCyc counts consecutive stall cycles and saturates at 15.
//
// Ports
//   clock, reset        core clock, asynchronous active-low reset
//   opBraFlush          branch flush; cancels the current bundle
//   l1Req/l1IsLoad/l1RegId   lane-1 memory op
//   l2Req/l2IsLoad/l2RegId   lane-2 memory op
//   memDataIn           L1D return data
//   memDataOK           L1D status: 00 idle, 01 done, 10 hold, 11 fault
//   memReq/memLane      lane serviced this cycle (0 = lane 1, 1 = lane 2)
//   exHold              pipeline stall, bundle not complete
//   exFault             one-cycle memory fault pulse
//   l1ResId/l1ResVal    lane-1 writeback (ZZR_ID when no writeback)
//   l2ResId/l2ResVal    lane-2 writeback (ZZR_ID when no writeback)
//   holdCyc             consecutive hold cycles, saturating at 15
// ---------------------------------------------------------------------------
module ex_memlane_sched #(
    parameter logic [5:0] ZZR_ID = 6'h3F,
    parameter int         DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              opBraFlush,
    input  logic              l1Req,
    input  logic              l1IsLoad,
    input  logic [5:0]        l1RegId,
    input  logic              l2Req,
    input  logic              l2IsLoad,
    input  logic [5:0]        l2RegId,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic [1:0]        memDataOK,
    output logic              memReq,
    output logic              memLane,
    output logic              exHold,
    output logic              exFault,
    output logic [5:0]        l1ResId,
    output logic [DATA_W-1:0] l1ResVal,
    output logic [5:0]        l2ResId,
    output logic [DATA_W-1:0] l2ResVal,
    output logic [3:0]        holdCyc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN2 = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_act;      // low from reset assertion to first clock after release
    logic [5:0]        r_l1Id;     // latched lane-1 writeback ID
    logic [DATA_W-1:0] r_l1Data;   // latched lane-1 load data
    logic [3:0]        r_holdCyc;

    state_t            w_next;
    logic              w_latch;
    logic [5:0]        w_l1Id;
    logic              w_ok;
    logic              w_flt;

    assign w_ok    = (memDataOK == 2'b01);
    assign w_flt   = (memDataOK == 2'b11);
    assign holdCyc = r_holdCyc;

    // Lane-1 writeback ID as produced by the current response: faults and
    // stores write nothing.
    assign w_l1Id  = (w_ok && l1IsLoad) ? l1RegId : ZZR_ID;

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        memReq   = 1'b0;
        memLane  = 1'b0;
        exHold   = 1'b0;
        exFault  = 1'b0;
        l1ResId  = ZZR_ID;
        l1ResVal = '0;
        l2ResId  = ZZR_ID;
        l2ResVal = '0;

        // r_act gates every combinational output so that asserting reset
        // silences the port immediately even if requests are still driven.
        if (!r_act) begin
            w_next = IDLE;
        end else if (opBraFlush) begin
            // Flush beats completion and fault in the same cycle.
            w_next = IDLE;
        end else if (r_state == RUN2) begin
            memReq  = 1'b1;
            memLane = 1'b1;
            if (w_ok || w_flt) begin
                exFault  = w_flt;
                l1ResId  = r_l1Id;
                l1ResVal = r_l1Data;
                l2ResId  = (w_ok && l2IsLoad) ? l2RegId : ZZR_ID;
                l2ResVal = w_ok ? memDataIn : '0;
                w_next   = IDLE;
            end else begin
                exHold = 1'b1;
            end
        end else if (l1Req) begin
            memReq = 1'b1;
            if (w_ok || w_flt) begin
                exFault = w_flt;
                if (l2Req) begin
                    // A lane-1 fault still hands over to lane 2.
                    exHold  = 1'b1;
                    w_latch = 1'b1;
                    w_next  = RUN2;
                end else begin
                    l1ResId  = w_l1Id;
                    l1ResVal = w_ok ? memDataIn : '0;
                end
            end else begin
                // 00 on a serviced lane means no response yet.
                exHold = 1'b1;
            end
        end else if (l2Req) begin
            // Lane-2-only bundle completes directly from IDLE.
            memReq  = 1'b1;
            memLane = 1'b1;
            if (w_ok || w_flt) begin
                exFault  = w_flt;
                l2ResId  = (w_ok && l2IsLoad) ? l2RegId : ZZR_ID;
                l2ResVal = w_ok ? memDataIn : '0;
            end else begin
                exHold = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_act     <= 1'b0;
            r_l1Id    <= ZZR_ID;
            r_l1Data  <= '0;
            r_holdCyc <= 4'd0;
        end else begin
            r_act   <= 1'b1;
            r_state <= w_next;
            if (w_latch) begin
                r_l1Id   <= w_l1Id;
                r_l1Data <= w_ok ? memDataIn : '0;
            end
            if (!exHold)
                r_holdCyc <= 4'd0;
            else if (r_holdCyc != 4'hF)
                r_holdCyc <= r_holdCyc + 4'd1;
        end
    end

endmodule
